// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic widths and divider FSM encoding
package arith_pkg;
   localparam int DW_DEF = 16;
   localparam int VW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;
endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step #(
   parameter int VW = 8
) (
   input  logic [VW-1:0] p,
   input  logic          din,
   input  logic [VW-1:0] d,
   output logic [VW-1:0] p_next,
   output logic          q_bit
);
   logic [VW:0] t;

   assign t = {p, din};

   // The compare needs VW+1 bits; the difference always fits VW bits since it is below d.
   always_comb begin
      p_next = t[VW-1:0];
      q_bit  = 1'b0;
      if (t >= {1'b0, d}) begin
         p_next = t[VW-1:0] - d;
         q_bit  = 1'b1;
      end
   end
endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
module seq_divider
   import arith_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);
   localparam int CW = $clog2(DW + 1);

   div_state_t    state;
   logic [CW-1:0] cnt;
   logic [DW-1:0] q_reg;
   logic [VW-1:0] p_reg;
   logic [VW-1:0] d_reg;
   logic          zero_pend;
   logic [VW-1:0] p_next;
   logic          q_bit;
   logic [DW-1:0] q_next;

   div_step #(.VW(VW)) u_step (
      .p      (p_reg),
      .din    (q_reg[DW-1]),
      .d      (d_reg),
      .p_next (p_next),
      .q_bit  (q_bit)
   );

   assign q_next = {q_reg[DW-2:0], q_bit};

   // A zero divisor spends one idle cycle in zero_pend so done lands one edge after acceptance.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         q_reg     <= '0;
         p_reg     <= '0;
         d_reg     <= '0;
         zero_pend <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         div_zero  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (zero_pend) begin
            zero_pend <= 1'b0;
            state     <= DONE;
            done      <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
         end else begin
            case (state)
               RUN: begin
                  q_reg <= q_next;
                  p_reg <= p_next;
                  cnt   <= cnt - 1'b1;
                  if (cnt == CW'(1)) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     quotient  <= q_next;
                     remainder <= p_next;
                  end
               end
               default: begin
                  state <= IDLE;
                  if (start) begin
                     if (divisor != '0) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        q_reg    <= dividend;
                        p_reg    <= '0;
                        d_reg    <= divisor;
                        cnt      <= CW'(DW);
                        div_zero <= 1'b0;
                     end else begin
                        zero_pend <= 1'b1;
                     end
                  end
               end
            endcase
         end
      end
   end
endmodule
